// File: rtl/counter_pkg.sv
// Shared counter-library definitions: counting mode constants and the
// next-state select encoding used by the step up/down counter.
package counter_pkg;

    // Behaviour at a range boundary: wrap modulo (limit+1) or clamp.
    typedef enum logic [0:0] {
        CNT_MODE_WRAP = 1'b0,
        CNT_MODE_SAT  = 1'b1
    } cnt_mode_t;

    // Which kind of update the counter performs this cycle.
    typedef enum logic [2:0] {
        HOLD  = 3'd0,
        LOAD  = 3'd1,
        UP    = 3'd2,
        DOWN  = 3'd3,
        RESET = 3'd4
    } cnt_sel_t;

endpackage

// File: rtl/step_updown_counter_dff.sv
// Parametrised D flip-flop register with synchronous active-high reset to zero.
module step_updown_counter_dff #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Register the next state; reset clears every bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/step_updown_counter.sv
// Programmable-stride up/down counter over the range 0..limit with load,
// boundary pulse and sticky illegal-step flag.
// Build option: define STEP_CNT_SAT_EN to clamp at the range bounds instead
// of wrapping modulo (limit+1).
module step_updown_counter
    import counter_pkg::*;
#(
    parameter int N = 8,
    parameter int S = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic [S-1:0] step,
    input  logic [N-1:0] limit,
    output logic [N-1:0] out,
    output logic         wrap,
    output logic         err,
    output logic         at_zero,
    output logic         at_limit
);

`ifdef STEP_CNT_SAT_EN
    localparam cnt_mode_t MODE = CNT_MODE_SAT;
`else
    localparam cnt_mode_t MODE = CNT_MODE_WRAP;
`endif

    logic [N+1:0] state_q;
    logic [N+1:0] state_d;
    cnt_sel_t     sel;

    logic [N-1:0] step_n;
    logic [N:0]   lim_p1;
    logic [N:0]   sum_up;
    logic [N:0]   up_wrapped;
    logic [N:0]   dn_wrapped;
    logic         step_zero;
    logic         step_big;
    logic         out_oor;
    logic [N-1:0] bound_lo;
    logic [N-1:0] bound_hi;

    assign {err, wrap, out} = state_q;
    assign at_zero  = (out == '0);
    assign at_limit = (out == limit);

    // Arithmetic is carried at N+1 bits so limit = 2^N-1 wraps modulo 2^N.
    assign step_n     = N'(step);
    assign lim_p1     = {1'b0, limit} + (N+1)'(1);
    assign sum_up     = {1'b0, out} + {1'b0, step_n};
    assign up_wrapped = sum_up - lim_p1;
    assign dn_wrapped = {1'b0, out} + lim_p1 - {1'b0, step_n};
    assign step_zero  = (step_n == '0);
    assign step_big   = (step_n > limit);
    assign out_oor    = (out > limit);

    // Landing values when crossing the bottom / top of the range.
    assign bound_lo = (MODE == CNT_MODE_SAT) ? '0    : N'(dn_wrapped);
    assign bound_hi = (MODE == CNT_MODE_SAT) ? limit : N'(up_wrapped);

    // Select the update kind by priority and compute {err, wrap, out} next.
    always_comb begin
        state_d = {err, 1'b0, out};
        if (rst) begin
            sel = RESET;
        end else if (load) begin
            sel = LOAD;
        end else if (inc && !dec) begin
            sel = UP;
        end else if (dec && !inc) begin
            sel = DOWN;
        end else begin
            sel = HOLD;
        end

        case (sel)
            RESET: begin
                state_d = '0;
            end
            LOAD: begin
                state_d = {1'b0, 1'b0, (load_val > limit) ? limit : load_val};
            end
            UP: begin
                if (step_zero) begin
                    state_d = {err, 1'b0, out};
                end else if (step_big) begin
                    state_d = {1'b1, 1'b0, out};
                end else if (out_oor) begin
                    state_d = {err, 1'b1, (MODE == CNT_MODE_SAT) ? limit : '0};
                end else if (sum_up <= {1'b0, limit}) begin
                    state_d = {err, 1'b0, N'(sum_up)};
                end else begin
                    state_d = {err, 1'b1, bound_hi};
                end
            end
            DOWN: begin
                if (step_zero) begin
                    state_d = {err, 1'b0, out};
                end else if (step_big) begin
                    state_d = {1'b1, 1'b0, out};
                end else if (out_oor) begin
                    state_d = {err, 1'b1, (MODE == CNT_MODE_SAT) ? limit : '0};
                end else if (out >= step_n) begin
                    state_d = {err, 1'b0, out - step_n};
                end else begin
                    state_d = {err, 1'b1, bound_lo};
                end
            end
            HOLD: begin
                state_d = {err, 1'b0, out};
            end
            default: begin
                state_d = {err, 1'b0, out};
            end
        endcase
    end

    step_updown_counter_dff #(
        .W (N + 2)
    ) u_state (
        .clk (clk),
        .rst (rst),
        .d   (state_d),
        .q   (state_q)
    );

endmodule
